// File: rtl/aes_keysched_nk.sv
// aes_keysched_nk: one AES key-expansion step (AES-128/192/256 via NK).
// Each accepted start produces the next NK words of the expanded key from
// the previous NK words, using the shared external S-box one byte per cycle.
//
// Handshake: start_i is accepted only while IDLE (busy_o low). A start seen
// while busy is dropped, not queued. ready_o pulses for one cycle when
// new_key_o is updated; new_key_o then holds until the next completion.
// start_i may be high in the ready_o cycle to begin the next step at once.
//
// Optional macro AES_KEYSCHED_CAPTURE_EN: when defined, last_key_i is
// registered at start; when undefined, last_key_i must stay stable from the
// start cycle through the ready_o cycle.
module aes_keysched_nk #(
  parameter int NK = 4,
  parameter int KW = 32 * NK
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_i,
  input  logic [3:0]    round_i,
  input  logic [KW-1:0] last_key_i,
  output logic [KW-1:0] new_key_o,
  output logic          ready_o,
  output logic          busy_o,
  output logic          sbox_access_o,
  output logic [7:0]    sbox_data_o,
  input  logic [7:0]    sbox_data_i,
  output logic          sbox_decrypt_o
);

  if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
    $error("aes_keysched_nk: NK must be 4, 6 or 8");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SUB  = 3'd1,
    S_FIN1 = 3'd2,
    S_SUB2 = 3'd3,
    S_FIN2 = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [1:0]    r_cnt;
  logic [1:0]    w_cnt_next;
  logic [7:0]    r_rcon;
  logic [23:0]   r_acc;         // S-box results in arrival order, oldest in [23:16]
  logic          w_acc_shift;
  logic [KW-1:0] r_new_key;
  logic [KW-1:0] w_new_key_next;
  logic          r_ready;
  logic          w_ready_next;
  logic          w_access;
  logic [7:0]    w_lookup;
  logic [KW-1:0] w_key;
  logic [31:0]   w_temp;
  logic [KW-1:0] w_fin1;
  logic [KW-1:0] w_fin2;
  logic [31:0]   w_n3;

  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    case (r)
      4'd1:    rcon_of = 8'h01;
      4'd2:    rcon_of = 8'h02;
      4'd3:    rcon_of = 8'h04;
      4'd4:    rcon_of = 8'h08;
      4'd5:    rcon_of = 8'h10;
      4'd6:    rcon_of = 8'h20;
      4'd7:    rcon_of = 8'h40;
      4'd8:    rcon_of = 8'h80;
      4'd9:    rcon_of = 8'h1b;
      4'd10:   rcon_of = 8'h36;
      default: rcon_of = 8'h00;
    endcase
  endfunction

  // Byte k of a word, most significant byte first.
  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] k);
    case (k)
      2'd0:    byte_of = w[31:24];
      2'd1:    byte_of = w[23:16];
      2'd2:    byte_of = w[15:8];
      default: byte_of = w[7:0];
    endcase
  endfunction

`ifdef AES_KEYSCHED_CAPTURE_EN
  logic [KW-1:0] r_key;

  // Hold the caller's key for the whole step so the input may change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_key <= '0;
    end else if (r_state == S_IDLE && start_i) begin
      r_key <= last_key_i;
    end
  end

  assign w_key = (r_state == S_IDLE) ? last_key_i : r_key;
`else
  assign w_key = last_key_i;
`endif

  // RotWord places result 0 in the low byte; result 3 arrives live in FIN1.
  assign w_temp = {r_acc[15:8], r_acc[7:0], sbox_data_i, r_acc[23:16]};

  // First half of the step: n0 = temp ^ w0 ^ Rcon, then the xor chain.
  always_comb begin
    logic [31:0] w_p;
    w_fin1 = '0;
    w_p    = w_temp ^ {r_rcon, 24'h0};
    for (int j = 0; j < NK; j++) begin
      w_p = w_p ^ w_key[KW-1-32*j -: 32];
      w_fin1[KW-1-32*j -: 32] = w_p;
    end
  end

  if (NK == 8) begin : g_nk8
    logic [127:0] r_half;
    logic [31:0]  w_sub2;
    logic [31:0]  w_n4;
    logic [31:0]  w_n5;
    logic [31:0]  w_n6;
    logic [31:0]  w_n7;

    // Keep n0..n3 while the SubWord(n3) lookups run.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_half <= '0;
      end else if (r_state == S_FIN1) begin
        r_half <= w_fin1[KW-1 -: 128];
      end
    end

    // Second half: SubWord(n3) without rotation or Rcon, then the chain.
    assign w_sub2 = {r_acc, sbox_data_i};
    assign w_n4   = w_sub2 ^ w_key[127:96];
    assign w_n5   = w_n4 ^ w_key[95:64];
    assign w_n6   = w_n5 ^ w_key[63:32];
    assign w_n7   = w_n6 ^ w_key[31:0];
    assign w_fin2 = {r_half, w_n4, w_n5, w_n6, w_n7};
    assign w_n3   = r_half[31:0];
  end else begin : g_nk46
    assign w_fin2 = '0;
    assign w_n3   = '0;
  end

  // Next-state, S-box port and result-update decode.
  always_comb begin
    w_next         = r_state;
    w_cnt_next     = r_cnt;
    w_acc_shift    = 1'b0;
    w_new_key_next = r_new_key;
    w_ready_next   = 1'b0;
    w_access       = 1'b0;
    w_lookup       = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_access   = 1'b1;
          w_lookup   = byte_of(w_key[31:0], 2'd0);
          w_cnt_next = 2'd1;
          w_next     = S_SUB;
        end
      end
      S_SUB: begin
        w_access    = 1'b1;
        w_lookup    = byte_of(w_key[31:0], r_cnt);
        w_acc_shift = 1'b1;
        if (r_cnt == 2'd3) begin
          w_cnt_next = 2'd0;
          w_next     = S_FIN1;
        end else begin
          w_cnt_next = r_cnt + 2'd1;
        end
      end
      S_FIN1: begin
        w_access = 1'b1;
        if (NK == 8) begin
          w_cnt_next = 2'd0;
          w_next     = S_SUB2;
        end else begin
          w_new_key_next = w_fin1;
          w_ready_next   = 1'b1;
          w_next         = S_IDLE;
        end
      end
      S_SUB2: begin
        w_access    = 1'b1;
        w_lookup    = byte_of(w_n3, r_cnt);
        w_acc_shift = (r_cnt != 2'd0);
        if (r_cnt == 2'd3) begin
          w_cnt_next = 2'd0;
          w_next     = S_FIN2;
        end else begin
          w_cnt_next = r_cnt + 2'd1;
        end
      end
      S_FIN2: begin
        w_access       = 1'b1;
        w_new_key_next = w_fin2;
        w_ready_next   = 1'b1;
        w_next         = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State, counter, Rcon capture, result collection and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 2'd0;
      r_rcon    <= 8'h00;
      r_acc     <= 24'h0;
      r_new_key <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= w_cnt_next;
      r_new_key <= w_new_key_next;
      r_ready   <= w_ready_next;
      if (r_state == S_IDLE && start_i) begin
        r_rcon <= rcon_of(round_i);
      end
      if (w_acc_shift) begin
        r_acc <= {r_acc[15:0], sbox_data_i};
      end
    end
  end

  assign new_key_o      = r_new_key;
  assign ready_o        = r_ready;
  assign busy_o         = (r_state != S_IDLE);
  assign sbox_access_o  = w_access;
  assign sbox_data_o    = w_lookup;
  assign sbox_decrypt_o = 1'b0;

endmodule

// File: tb/tb_aes_keysched_nk.sv
// Directed bench for aes_keysched_nk: NK=4, 6 and 8 instances, each with a
// registered forward S-box model on its lookup port.
module tb_aes_keysched_nk;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] K4 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] E4 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] F4 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [191:0] K6 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [191:0] E6 = 192'hfe0c91f72402f5a5ec12068e6c827f6b0e7a95b95c56fec2;
  localparam logic [255:0] K8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] E8 = 256'h9ba354118e6925afa51a8b5f2067fcdea8b09c1a93d194cdbe49846eb75d5b9a;

  logic [2047:0] sbox_flat = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic         start4, start6, start8;
  logic [3:0]   round4, round6, round8;
  logic [127:0] key4, nk4;
  logic [191:0] key6, nk6;
  logic [255:0] key8, nk8;
  logic         ready4, ready6, ready8;
  logic         busy4, busy6, busy8;
  logic         acc4, acc6, acc8;
  logic [7:0]   sdata4, sdata6, sdata8;
  logic [7:0]   sbin4, sbin6, sbin8;
  logic         dec4, dec6, dec8;

  aes_keysched_nk #(.NK(4)) u_nk4 (
    .clk(clk), .reset(reset), .start_i(start4), .round_i(round4),
    .last_key_i(key4), .new_key_o(nk4), .ready_o(ready4), .busy_o(busy4),
    .sbox_access_o(acc4), .sbox_data_o(sdata4), .sbox_data_i(sbin4),
    .sbox_decrypt_o(dec4)
  );

  aes_keysched_nk #(.NK(6)) u_nk6 (
    .clk(clk), .reset(reset), .start_i(start6), .round_i(round6),
    .last_key_i(key6), .new_key_o(nk6), .ready_o(ready6), .busy_o(busy6),
    .sbox_access_o(acc6), .sbox_data_o(sdata6), .sbox_data_i(sbin6),
    .sbox_decrypt_o(dec6)
  );

  aes_keysched_nk #(.NK(8)) u_nk8 (
    .clk(clk), .reset(reset), .start_i(start8), .round_i(round8),
    .last_key_i(key8), .new_key_o(nk8), .ready_o(ready8), .busy_o(busy8),
    .sbox_access_o(acc8), .sbox_data_o(sdata8), .sbox_data_i(sbin8),
    .sbox_decrypt_o(dec8)
  );

  // Registered S-box models: result valid the cycle after the request.
  always @(posedge clk) begin
    sbin4 <= sbox_flat[2047 - 8*int'(sdata4) -: 8];
    sbin6 <= sbox_flat[2047 - 8*int'(sdata6) -: 8];
    sbin8 <= sbox_flat[2047 - 8*int'(sdata8) -: 8];
  end

  // Driver: start one step on instance sel, return the cycle ready_o is seen
  // (start cycle = 0), or -1 if it never appears within the budget.
  task automatic run_step(input int sel, input logic [255:0] key,
                          input logic [3:0] rnd, output int cyc);
    logic rdy;
    case (sel)
      4:       begin key4 = key[127:0]; round4 = rnd; start4 = 1'b1; end
      6:       begin key6 = key[191:0]; round6 = rnd; start6 = 1'b1; end
      default: begin key8 = key;        round8 = rnd; start8 = 1'b1; end
    endcase
    @(negedge clk);
    start4 = 1'b0;
    start6 = 1'b0;
    start8 = 1'b0;
    cyc = -1;
    for (int c = 1; c <= 20; c++) begin
      rdy = (sel == 4) ? ready4 : (sel == 6) ? ready6 : ready8;
      if (rdy) begin
        cyc = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #1;
    total++; if (nk4 !== 128'h0) begin bad++; $display("FAIL rst_nk4 got=%h exp=0", nk4); end
    total++; if (nk6 !== 192'h0) begin bad++; $display("FAIL rst_nk6 got=%h exp=0", nk6); end
    total++; if (nk8 !== 256'h0) begin bad++; $display("FAIL rst_nk8 got=%h exp=0", nk8); end
    total++; if ({ready4, ready6, ready8} !== 3'b000) begin bad++; $display("FAIL rst_ready got=%b exp=000", {ready4, ready6, ready8}); end
    total++; if ({busy4, busy6, busy8} !== 3'b000) begin bad++; $display("FAIL rst_busy got=%b exp=000", {busy4, busy6, busy8}); end
    total++; if ({acc4, acc6, acc8} !== 3'b000) begin bad++; $display("FAIL rst_access got=%b exp=000", {acc4, acc6, acc8}); end
    total++; if ({sdata4, sdata6, sdata8} !== 24'h0) begin bad++; $display("FAIL rst_sdata got=%h exp=0", {sdata4, sdata6, sdata8}); end
    total++; if ({dec4, dec6, dec8} !== 3'b000) begin bad++; $display("FAIL rst_decrypt got=%b exp=000", {dec4, dec6, dec8}); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Cycle-by-cycle port behaviour of one NK=4 step.
  task automatic test_nk4;
    logic [7:0] exp_d [7] = '{8'h09, 8'hcf, 8'h4f, 8'h3c, 8'h00, 8'h00, 8'h00};
    logic [6:0] exp_acc  = 7'b0011111;
    logic [6:0] exp_rdy  = 7'b0100000;
    logic [6:0] exp_busy = 7'b0011110;
    key4 = K4;
    round4 = 4'd1;
    start4 = 1'b1;
    for (int c = 0; c < 7; c++) begin
      #1;
      total++; if (sdata4 !== exp_d[c]) begin bad++; $display("FAIL nk4_sdata c=%0d got=%h exp=%h", c, sdata4, exp_d[c]); end
      total++; if (acc4 !== exp_acc[c]) begin bad++; $display("FAIL nk4_access c=%0d got=%b exp=%b", c, acc4, exp_acc[c]); end
      total++; if (ready4 !== exp_rdy[c]) begin bad++; $display("FAIL nk4_ready c=%0d got=%b exp=%b", c, ready4, exp_rdy[c]); end
      total++; if (busy4 !== exp_busy[c]) begin bad++; $display("FAIL nk4_busy c=%0d got=%b exp=%b", c, busy4, exp_busy[c]); end
      if (c >= 5) begin
        total++; if (nk4 !== E4) begin bad++; $display("FAIL nk4_key c=%0d got=%h exp=%h", c, nk4, E4); end
      end
      @(negedge clk);
      start4 = 1'b0;
    end
  endtask

  task automatic test_nk6;
    int cyc;
    run_step(6, {64'h0, K6}, 4'd1, cyc);
    total++; if (cyc !== 5) begin bad++; $display("FAIL nk6_latency got=%0d exp=5", cyc); end
    total++; if (nk6 !== E6) begin bad++; $display("FAIL nk6_key got=%h exp=%h", nk6, E6); end
    run_step(6, 256'h0, 4'd1, cyc);
    total++; if (nk6 !== {6{32'h62636363}}) begin bad++; $display("FAIL nk6_zero got=%h exp=%h", nk6, {6{32'h62636363}}); end
  endtask

  task automatic test_nk8;
    int cyc;
    run_step(8, K8, 4'd1, cyc);
    total++; if (cyc !== 10) begin bad++; $display("FAIL nk8_latency got=%0d exp=10", cyc); end
    total++; if (nk8 !== E8) begin bad++; $display("FAIL nk8_key got=%h exp=%h", nk8, E8); end
    @(negedge clk);
    total++; if (ready8 !== 1'b0) begin bad++; $display("FAIL nk8_ready_pulse got=%b exp=0", ready8); end
    total++; if (nk8 !== E8) begin bad++; $display("FAIL nk8_hold got=%h exp=%h", nk8, E8); end
    run_step(8, 256'h0, 4'd1, cyc);
    total++; if (nk8 !== {{4{32'h62636363}}, {4{32'haafbfbfb}}}) begin bad++; $display("FAIL nk8_zero got=%h exp=%h", nk8, {{4{32'h62636363}}, {4{32'haafbfbfb}}}); end
  endtask

  // Rcon table edges on a zero key: each word is {63^Rcon, 636363}.
  task automatic test_rcon;
    logic [3:0] rnds [6] = '{4'd0, 4'd1, 4'd9, 4'd10, 4'd11, 4'd15};
    logic [7:0] tops [6] = '{8'h63, 8'h62, 8'h78, 8'h55, 8'h63, 8'h63};
    logic [127:0] exp;
    int cyc;
    for (int i = 0; i < 6; i++) begin
      exp = {4{tops[i], 24'h636363}};
      run_step(4, 256'h0, rnds[i], cyc);
      total++; if (cyc !== 5) begin bad++; $display("FAIL rcon_latency round=%0d got=%0d exp=5", rnds[i], cyc); end
      total++; if (nk4 !== exp) begin bad++; $display("FAIL rcon_key round=%0d got=%h exp=%h", rnds[i], nk4, exp); end
    end
  endtask

  // Ten chained NK=4 steps, restarted in each ready cycle, with a spurious
  // start and a round_i change during every step.
  task automatic test_back_to_back;
    int cyc;
    key4 = K4;
    round4 = 4'd1;
    start4 = 1'b1;
    for (int s = 1; s <= 10; s++) begin
      @(negedge clk);
      start4 = 1'b0;
      cyc = -1;
      for (int c = 1; c <= 20; c++) begin
        if (ready4) begin
          cyc = c;
          break;
        end
        start4 = (c == 2);
        if (c == 2) round4 = 4'($urandom_range(0, 15));
        @(negedge clk);
      end
      total++; if (cyc !== 5) begin bad++; $display("FAIL b2b_latency step=%0d got=%0d exp=5", s, cyc); end
      if (s == 1) begin
        total++; if (nk4 !== E4) begin bad++; $display("FAIL b2b_step1 got=%h exp=%h", nk4, E4); end
      end
      if (s < 10) begin
        key4 = nk4;
        round4 = 4'(s + 1);
        start4 = 1'b1;
      end
    end
    start4 = 1'b0;
    total++; if (nk4 !== F4) begin bad++; $display("FAIL b2b_final got=%h exp=%h", nk4, F4); end
  endtask

  // Reset in the middle of a step, then a clean restart.
  task automatic test_reset_mid;
    logic seen;
    int cyc;
    key4 = K4; round4 = 4'd1; start4 = 1'b1;
    key8 = K8; round8 = 4'd1; start8 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    start8 = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    total++; if (nk4 !== 128'h0) begin bad++; $display("FAIL mid_nk4 got=%h exp=0", nk4); end
    total++; if (nk8 !== 256'h0) begin bad++; $display("FAIL mid_nk8 got=%h exp=0", nk8); end
    total++; if ({ready4, busy4, acc4} !== 3'b000) begin bad++; $display("FAIL mid_ctl4 got=%b exp=000", {ready4, busy4, acc4}); end
    total++; if ({ready8, busy8, acc8} !== 3'b000) begin bad++; $display("FAIL mid_ctl8 got=%b exp=000", {ready8, busy8, acc8}); end
    total++; if (sdata4 !== 8'h00) begin bad++; $display("FAIL mid_sdata4 got=%h exp=00", sdata4); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (ready4 || ready8) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_no_ready got=%b exp=0", seen); end
    run_step(4, {128'h0, K4}, 4'd1, cyc);
    total++; if (cyc !== 5) begin bad++; $display("FAIL mid_restart_latency got=%0d exp=5", cyc); end
    total++; if (nk4 !== E4) begin bad++; $display("FAIL mid_restart_key got=%h exp=%h", nk4, E4); end
  endtask

  initial begin
    reset  = 1'b0;
    start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
    round4 = 4'd0; round6 = 4'd0; round8 = 4'd0;
    key4   = '0;   key6   = '0;   key8   = '0;
    test_reset;
    test_nk4;
    test_nk6;
    test_nk8;
    test_rcon;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
